// File: rtl/stream_deserializer_if.sv
// Bundles the serial input side and the word output side of stream_deserializer.
//   stream       serial data bit
//   stream_valid qualifies stream on a rising edge
//   sync_clr     synchronous word-alignment restart
//   ready        consumer accepts the held word when ena & ready
//   data_out     assembled WIDTH-bit word, stable while ena = 1
//   ena          data_out holds a valid word
//   data_sel     header phase complete (level)
//   overflow     sticky: a completed word was dropped
// master: the producer/consumer side driving the stream and ready.
// slave:  the deserializer itself.
interface stream_deserializer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             stream;
  logic             stream_valid;
  logic             sync_clr;
  logic             ready;
  logic [WIDTH-1:0] data_out;
  logic             ena;
  logic             data_sel;
  logic             overflow;

  modport master (
    output stream,
    output stream_valid,
    output sync_clr,
    output ready,
    input  data_out,
    input  ena,
    input  data_sel,
    input  overflow
  );

  modport slave (
    input  stream,
    input  stream_valid,
    input  sync_clr,
    input  ready,
    output data_out,
    output ena,
    output data_sel,
    output overflow
  );

endinterface

// File: rtl/stream_deserializer.sv
// Serial-to-parallel converter: packs qualified serial bits into WIDTH-bit words (LSB-first or
// MSB-first), presents each word through a one-word holding register with a valid/ready
// handshake, and raises data_sel once HEADER_BITS bits have been accepted.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    stream_deserializer_if slave modport (stream, stream_valid, sync_clr, ready in;
//          data_out, ena, data_sel, overflow out). All outputs are registered.
module stream_deserializer #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HEADER_BITS = 20,
  parameter bit          MSB_FIRST   = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  stream_deserializer_if.slave  bus
);

  localparam int unsigned CntW    = $clog2(WIDTH);
  localparam int unsigned HdrW    = (HEADER_BITS > 0) ? $clog2(HEADER_BITS + 1) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);
  localparam logic [HdrW-1:0] HdrMax  = HdrW'(HEADER_BITS);
  localparam bit HdrZero = (HEADER_BITS == 0);

  typedef enum logic [0:0] {StEmpty, StFull} hold_state_e;

  // Bit assembly
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [CntW-1:0]  pos;
  logic [CntW-1:0]  idx;
  logic [WIDTH-1:0] assembled;
  logic             word_done;

  // Holding register
  hold_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overflow_q, overflow_d;
  logic             consume;

  // Header counter
  logic [HdrW-1:0]  hdr_cnt_q, hdr_cnt_d;
  logic             data_sel_q, data_sel_d;

  // sync_clr restarts alignment before the current bit is placed, so a bit arriving with
  // sync_clr lands in the first-bit position and can never complete a word.
  always_comb begin
    pos       = bus.sync_clr ? '0 : bit_cnt_q;
    idx       = MSB_FIRST ? (LastIdx - pos) : pos;
    assembled = bus.sync_clr ? '0 : partial_q;
    if (bus.stream_valid) begin
      assembled[idx] = bus.stream;
    end
    word_done = bus.stream_valid && (pos == LastIdx);

    bit_cnt_d = bit_cnt_q;
    partial_d = partial_q;
    if (bus.stream_valid) begin
      bit_cnt_d = word_done ? '0 : pos + CntW'(1);
      partial_d = word_done ? '0 : assembled;
    end else if (bus.sync_clr) begin
      bit_cnt_d = '0;
      partial_d = '0;
    end
  end

  // Holding register FSM: a completed word loads when the register is empty or being drained
  // this cycle; otherwise it is dropped and overflow latches.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    overflow_d = overflow_q;
    consume    = (state_q == StFull) && bus.ready;
    case (state_q)
      StEmpty: begin
        if (word_done) begin
          data_d  = assembled;
          state_d = StFull;
        end
      end
      StFull: begin
        if (word_done) begin
          if (consume) begin
            data_d = assembled;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Header counter saturates at HEADER_BITS; data_sel is registered alongside it.
  always_comb begin
    hdr_cnt_d = hdr_cnt_q;
    if (bus.stream_valid && (hdr_cnt_q != HdrMax)) begin
      hdr_cnt_d = hdr_cnt_q + HdrW'(1);
    end
    data_sel_d = (hdr_cnt_d == HdrMax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      partial_q  <= '0;
      state_q    <= StEmpty;
      data_q     <= '0;
      overflow_q <= 1'b0;
      hdr_cnt_q  <= '0;
      data_sel_q <= HdrZero;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      partial_q  <= partial_d;
      state_q    <= state_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      hdr_cnt_q  <= hdr_cnt_d;
      data_sel_q <= data_sel_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.ena      = (state_q == StFull);
  assign bus.data_sel = data_sel_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_stream_deserializer.sv
// Directed bench: one LSB-first and one MSB-first instance share the same stimulus.
module tb_stream_deserializer;

  logic clk;
  logic rst_n;
  logic stream;
  logic stream_valid;
  logic sync_clr;
  logic ready;

  int total;
  int bad;
  int nbits;

  stream_deserializer_if #(.WIDTH(8)) bus_lsb ();
  stream_deserializer_if #(.WIDTH(8)) bus_msb ();

  assign bus_lsb.stream       = stream;
  assign bus_lsb.stream_valid = stream_valid;
  assign bus_lsb.sync_clr     = sync_clr;
  assign bus_lsb.ready        = ready;
  assign bus_msb.stream       = stream;
  assign bus_msb.stream_valid = stream_valid;
  assign bus_msb.sync_clr     = sync_clr;
  assign bus_msb.ready        = ready;

  stream_deserializer #(
    .WIDTH      (8),
    .HEADER_BITS(20),
    .MSB_FIRST  (1'b0)
  ) u_dut_lsb (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_lsb)
  );

  stream_deserializer #(
    .WIDTH      (8),
    .HEADER_BITS(20),
    .MSB_FIRST  (1'b1)
  ) u_dut_msb (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_msb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle 1 time unit past it.
  task automatic step(input logic b, input logic v, input logic clr, input logic rdy);
    stream       = b;
    stream_valid = v;
    sync_clr     = clr;
    ready        = rdy;
    @(posedge clk);
    #1;
    if (v) begin
      nbits++;
      if (nbits == 19) check("hdr_19_bits", {31'd0, bus_lsb.data_sel}, 32'd0);
      if (nbits == 20) check("hdr_20_bits", {31'd0, bus_lsb.data_sel}, 32'd1);
    end
  endtask

  // Sends w bit 0 first; rdy_last applies on the completing bit only.
  task automatic send_word(input logic [7:0] w, input logic rdy_rest, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      step(w[i], 1'b1, 1'b0, (i == 7) ? rdy_last : rdy_rest);
    end
  endtask

  initial begin
    logic [7:0] w;
    total        = 0;
    bad          = 0;
    nbits        = 0;
    stream       = 1'b0;
    stream_valid = 1'b0;
    sync_clr     = 1'b0;
    ready        = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", {24'd0, bus_lsb.data_out}, 32'h0);
    check("rst_ena", {31'd0, bus_lsb.ena}, 32'd0);
    check("rst_ovf", {31'd0, bus_lsb.overflow}, 32'd0);
    check("rst_sel", {31'd0, bus_lsb.data_sel}, 32'd0);
    rst_n = 1'b1;

    // Basic word, both bit orders
    w = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      step(w[i], 1'b1, 1'b0, 1'b1);
      if (i == 6) check("ena_before_last", {31'd0, bus_lsb.ena}, 32'd0);
    end
    check("w1_ena", {31'd0, bus_lsb.ena}, 32'd1);
    check("w1_lsb", {24'd0, bus_lsb.data_out}, 32'h4D);
    check("w1_msb", {24'd0, bus_msb.data_out}, 32'hB2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("w1_ena_one_cycle", {31'd0, bus_lsb.ena}, 32'd0);

    // 16 continuous bits; header crosses 20 inside here
    send_word(8'h1E, 1'b1, 1'b1);
    check("w2_ena", {31'd0, bus_msb.ena}, 32'd1);
    check("w2_lsb", {24'd0, bus_lsb.data_out}, 32'h1E);
    check("w2_msb", {24'd0, bus_msb.data_out}, 32'h78);
    send_word(8'h33, 1'b1, 1'b1);
    check("w3_ena", {31'd0, bus_msb.ena}, 32'd1);
    check("w3_lsb", {24'd0, bus_lsb.data_out}, 32'h33);
    check("w3_msb", {24'd0, bus_msb.data_out}, 32'hCC);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Completion coinciding with consumption replaces the word without overflow
    send_word(8'h0F, 1'b0, 1'b0);
    check("c_lsb", {24'd0, bus_lsb.data_out}, 32'h0F);
    check("c_msb", {24'd0, bus_msb.data_out}, 32'hF0);
    send_word(8'h80, 1'b0, 1'b1);
    check("d_ena", {31'd0, bus_lsb.ena}, 32'd1);
    check("d_lsb", {24'd0, bus_lsb.data_out}, 32'h80);
    check("d_msb", {24'd0, bus_msb.data_out}, 32'h01);
    check("d_no_ovf", {31'd0, bus_lsb.overflow}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("d_drained", {31'd0, bus_lsb.ena}, 32'd0);

    // Overflow: word B dropped while A held
    send_word(8'h11, 1'b0, 1'b0);
    check("a_lsb", {24'd0, bus_lsb.data_out}, 32'h11);
    check("a_ovf", {31'd0, bus_lsb.overflow}, 32'd0);
    send_word(8'h22, 1'b0, 1'b0);
    check("b_keep_lsb", {24'd0, bus_lsb.data_out}, 32'h11);
    check("b_keep_msb", {24'd0, bus_msb.data_out}, 32'h88);
    check("b_ovf", {31'd0, bus_msb.overflow}, 32'd1);
    check("b_ena", {31'd0, bus_lsb.ena}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_drain_ena", {31'd0, bus_lsb.ena}, 32'd0);
    check("ovf_sticky", {31'd0, bus_lsb.overflow}, 32'd1);

    // sync_clr realigns; the three leading bits never form a word
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("clr_no_word", {31'd0, bus_lsb.ena}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("clr_ena", {31'd0, bus_lsb.ena}, 32'd1);
    check("clr_lsb", {24'd0, bus_lsb.data_out}, 32'h01);
    check("clr_msb", {24'd0, bus_msb.data_out}, 32'h80);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 104 more bits: header stays saturated
    for (int i = 0; i < 104; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("long_sel", {31'd0, bus_lsb.data_sel}, 32'd1);
    check("long_data", {24'd0, bus_lsb.data_out}, 32'hFF);

    // Asynchronous reset mid-word
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("pre_rst_sel", {31'd0, bus_lsb.data_sel}, 32'd1);
    check("pre_rst_ovf", {31'd0, bus_lsb.overflow}, 32'd1);
    stream_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_data", {24'd0, bus_lsb.data_out}, 32'h0);
    check("arst_ena", {31'd0, bus_lsb.ena}, 32'd0);
    check("arst_sel", {31'd0, bus_lsb.data_sel}, 32'd0);
    check("arst_ovf", {31'd0, bus_msb.overflow}, 32'd0);
    rst_n = 1'b1;
    nbits = 0;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("post_rst_partial", {31'd0, bus_lsb.ena}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("post_rst_ena", {31'd0, bus_lsb.ena}, 32'd1);
    check("post_rst_lsb", {24'd0, bus_lsb.data_out}, 32'hFF);
    check("post_rst_msb", {24'd0, bus_msb.data_out}, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
